// File: rtl/bcd_subtractor_seq_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
// The master drives the request; the slave returns status and results.
interface bcd_subtractor_seq_if #(
    parameter int DIGITS = 4
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  bin;
    logic                  ready;
    logic                  valid;
    logic [4*DIGITS-1:0]   diff;
    logic                  borrow;
    logic                  err;

    modport master (
        output start, a, b, bin,
        input  ready, valid, diff, borrow, err
    );

    modport slave (
        input  start, a, b, bin,
        output ready, valid, diff, borrow, err
    );
endinterface

// File: rtl/bcd_subtractor_seq.sv
// Digit-serial BCD subtractor: diff = a - b - bin, one digit per clock,
// least significant digit first, with start/ready/valid handshake.
module bcd_subtractor_seq #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_subtractor_seq_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            br_q, br_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;

    logic [3:0]        a_dig;
    logic [3:0]        b_dig;
    logic signed [4:0] t;
    logic              neg;
    logic [3:0]        d_dig;
    logic              bad;
    int                lo;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    // Current digit difference with decimal correction on underflow
    always_comb begin
        lo    = int'(idx_q) * 4;
        a_dig = a_q[lo +: 4];
        b_dig = b_q[lo +: 4];
        t     = $signed({1'b0, a_dig})
              - $signed({1'b0, b_dig})
              - $signed({4'b0000, br_q});
        neg   = t[4];
        d_dig = neg ? 4'(t + 5'sd10) : t[3:0];
        bad   = has_bad(bus.a) | has_bad(bus.b);
    end

    // Next-state and next-output logic for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        ready_d  = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    idx_d    = '0;
                    br_d     = bus.bin;
                    err_d    = 1'b0;
                    borrow_d = 1'b0;
                    diff_d   = '0;
                    ready_d  = 1'b0;
                    if (bad) begin
                        err_d   = 1'b1;
                        br_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                diff_d[lo +: 4] = d_dig;
                br_d            = neg;
                idx_d           = idx_q + 1'b1;
                if (idx_q == IW'(DIGITS - 1)) state_d = DONE;
            end
            DONE: begin
                valid_d  = 1'b1;
                borrow_d = br_q;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.valid  = valid_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq: directed table, corner
// sequences and random operands against a decimal arithmetic model.
module tb_bcd_subtractor_seq;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk;
    logic rst_n;

    bcd_subtractor_seq_if #(.DIGITS(DIGITS)) bus ();

    bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         br;
        logic         er;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic void model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic bin,
                                  output logic [W-1:0] d,
                                  output logic br,
                                  output logic er,
                                  output int lat);
        int va, vb, r;
        logic [3:0] na, nb;
        er = 1'b0;
        va = 0;
        vb = 0;
        for (int i = 0; i < DIGITS; i++) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            if (na > 9 || nb > 9) er = 1'b1;
            va = va + int'(na) * pow10(i);
            vb = vb + int'(nb) * pow10(i);
        end
        d = '0;
        if (er) begin
            br  = 1'b0;
            lat = 1;
        end else begin
            r  = va - vb - int'(bin);
            br = (r < 0);
            if (r < 0) r = r + pow10(DIGITS);
            for (int i = 0; i < DIGITS; i++) begin
                d[4*i +: 4] = 4'((r / pow10(i)) % 10);
            end
            lat = DIGITS + 1;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, output int lat);
        @(negedge clk);
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta,
                            input logic [W-1:0] tb_, input logic tbin);
        logic [W-1:0] ed;
        logic         ebr, eer;
        int           elat, lat;
        model(ta, tb_, tbin, ed, ebr, eer, elat);
        chk({name, " ready"}, 32'(bus.ready), 32'd1);
        run_op(ta, tb_, tbin, lat);
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " diff"}, 32'(bus.diff), 32'(ed));
        chk({name, " borrow"}, 32'(bus.borrow), 32'(ebr));
        chk({name, " err"}, 32'(bus.err), 32'(eer));
        @(posedge clk);
        #1;
        chk({name, " pulse"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int   lat, pulses, first;
        logic [W-1:0] ra, rb, sd;
        logic sb;
        vectors     = 0;
        miscompares = 0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.bin     = 1'b0;
        rst_n       = 1'b0;

        tbl[0] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 5};
        tbl[1] = '{16'h0017, 16'h0042, 1'b0, 16'h9975, 1'b1, 1'b0, 5};
        tbl[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 5};
        tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 5};
        tbl[4] = '{16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
        tbl[5] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 5};
        tbl[6] = '{16'h0500, 16'h0500, 1'b1, 16'h9999, 1'b1, 1'b0, 5};
        tbl[7] = '{16'h0000, 16'h9999, 1'b0, 16'h0001, 1'b1, 1'b0, 5};
        tbl[8] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, 5};
        tbl[9] = '{16'h0001, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1, 1};

        #12;
        chk("rst ready", 32'(bus.ready), 32'd1);
        chk("rst valid", 32'(bus.valid), 32'd0);
        chk("rst diff", 32'(bus.diff), 32'd0);
        chk("rst borrow", 32'(bus.borrow), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
            chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d diff", i), 32'(bus.diff), 32'(tbl[i].d));
            chk($sformatf("tbl%0d borrow", i), 32'(bus.borrow),
                32'(tbl[i].br));
            chk($sformatf("tbl%0d err", i), 32'(bus.err), 32'(tbl[i].er));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d pulse", i), 32'(bus.valid), 32'd0);
            chk($sformatf("tbl%0d ready", i), 32'(bus.ready), 32'd1);
        end

        check_op("hold", 16'h0017, 16'h0042, 1'b0);
        sd = bus.diff;
        sb = bus.borrow;
        repeat (5) @(posedge clk);
        #1;
        chk("hold diff", 32'(bus.diff), 32'h9975);
        chk("hold borrow", 32'(bus.borrow), 32'd1);
        chk("hold ready", 32'(bus.ready), 32'd1);

        @(negedge clk);
        bus.a     = 16'h0042;
        bus.b     = 16'h0017;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("mid ready low", 32'(bus.ready), 32'd0);
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin
                bus.a     = 16'h9999;
                bus.b     = 16'h1111;
                bus.bin   = 1'b1;
                bus.start = 1'b1;
            end
            if (c == 3) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.valid) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    sd    = bus.diff;
                    sb    = bus.borrow;
                end
            end
        end
        chk("mid pulses", 32'(pulses), 32'd1);
        chk("mid latency", 32'(first), 32'(DIGITS + 1));
        chk("mid diff", 32'(sd), 32'h0025);
        chk("mid borrow", 32'(sb), 32'd0);

        @(negedge clk);
        bus.a     = 16'h0017;
        bus.b     = 16'h0042;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst ready", 32'(bus.ready), 32'd1);
        chk("arst valid", 32'(bus.valid), 32'd0);
        chk("arst diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.valid) pulses++;
        end
        chk("arst no pulse", 32'(pulses), 32'd0);
        check_op("post rst", 16'h0042, 16'h0017, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = '0;
            rb = '0;
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                ra[4*$urandom_range(0, DIGITS-1) +: 4] =
                    4'($urandom_range(10, 15));
            end
            if ($urandom_range(0, 9) == 0) rb = ra;
            check_op($sformatf("rnd%0d", k), ra, rb,
                     1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
